vga_scan_gen: RTL and testbench



---
 rtl/vga_scan_gen.sv | 237 +++++++++++++++++++++++
 tb/tb_vga_scan_gen.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_gen.sv
// ============================================================================
// vga_scan_gen
// ----------------------------------------------------------------------------
// Raster scan generator for the 800x600@60 Hz display path.
//
// The horizontal and vertical counters are the single source of truth for
// where the beam is. They are presented directly as o_X/o_Y so that sprite
// widgets and the colour mux can compute the composited colour for that
// coordinate. The colour comes back on i_redIn/i_greenIn/i_blueIn PIPE pixel
// ticks later. The raw sync and active flags are therefore pushed through a
// matching PIPE-stage delay line, so the pins see sync, blank and colour that
// all belong to the same pixel.
//
// o_frameTick is a one-clock pulse at the start of vertical blank. Widgets
// use it as a clock enable so that motion steps once per frame.
//
// Ports
//   clk           in   1   pixel-domain clock
//   reset         in   1   synchronous, active-high
//   i_pixEn       in   1   pixel-tick clock enable (tie high at 40 MHz)
//   o_X           out  11  horizontal count, 0..H_TOTAL-1
//   o_Y           out  11  vertical count, 0..V_TOTAL-1
//   o_active      out  1   combinational: X < H_VISIBLE && Y < V_VISIBLE
//   o_frameTick   out  1   one-clk pulse after the (H_TOTAL-1, V_VISIBLE-1)
//                          -> (0, V_VISIBLE) pixel tick
//   i_redIn       in   4   composited colour for the coordinate presented
//   i_greenIn     in   4   PIPE ticks earlier
//   i_blueIn      in   4
//   o_hsync       out  1   registered hsync, active level SYNC_POL
//   o_vsync       out  1   registered vsync, active level SYNC_POL
//   o_red         out  4   registered colour, forced to 0 in blanking
//   o_green       out  4
//   o_blue        out  4
//
// Parameters
//   H_VISIBLE/H_FRONT/H_SYNC/H_BACK : horizontal timing in pixels
//   V_VISIBLE/V_FRONT/V_SYNC/V_BACK : vertical timing in lines
//   SYNC_POL                        : active level of both syncs (1 = positive)
//   PIPE                            : render pipeline depth, 0..4
// The line and frame totals must each fit in 11 bits (<= 2047).
// ============================================================================
module vga_scan_gen #(
    parameter int H_VISIBLE = 800,
    parameter int H_FRONT   = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BACK    = 88,
    parameter int V_VISIBLE = 600,
    parameter int V_FRONT   = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BACK    = 23,
    parameter bit SYNC_POL  = 1'b1,
    parameter int PIPE      = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_pixEn,
    output logic [10:0] o_X,
    output logic [10:0] o_Y,
    output logic        o_active,
    output logic        o_frameTick,
    input  logic [3:0]  i_redIn,
    input  logic [3:0]  i_greenIn,
    input  logic [3:0]  i_blueIn,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic [3:0]  o_red,
    output logic [3:0]  o_green,
    output logic [3:0]  o_blue
);

    // ------------------------------------------------------------------------
    // Timing constants, all reduced to 11-bit unsigned values so that every
    // compare below is a plain 11-bit unsigned compare.
    // ------------------------------------------------------------------------
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] C_H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] C_V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] C_H_VIS      = 11'(H_VISIBLE);
    localparam logic [10:0] C_V_VIS      = 11'(V_VISIBLE);
    localparam logic [10:0] C_V_VIS_LAST = 11'(V_VISIBLE - 1);
    localparam logic [10:0] C_HS_START   = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] C_HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] C_VS_START   = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] C_VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic C_SYNC_ON  = SYNC_POL;
    localparam logic C_SYNC_OFF = ~SYNC_POL;

    // One delay-line entry is {hs, vs, act}; this is the idle/blank value.
    localparam logic [2:0] C_STAGE_IDLE = {C_SYNC_OFF, C_SYNC_OFF, 1'b0};

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [10:0] r_hCount;
    logic [10:0] r_vCount;
    logic        w_hLast;
    logic        w_vLast;
    logic        w_active;
    logic        w_hs0;
    logic        w_vs0;
    logic [2:0]  w_stage0;
    logic [2:0]  w_stageN;
    logic        r_hsync;
    logic        r_vsync;
    logic [3:0]  r_red;
    logic [3:0]  r_green;
    logic [3:0]  r_blue;
    logic        r_frameTick;

    // End-of-line and end-of-frame detection from the current counts.
    assign w_hLast = (r_hCount == C_H_LAST);
    assign w_vLast = (r_vCount == C_V_LAST);

    // ------------------------------------------------------------------------
    // Raster counters. The horizontal counter steps once per pixel tick and
    // wraps at the end of the line; the vertical counter only moves on that
    // wrap. Reset wins over the pixel enable so a mid-frame reset always lands
    // on (0,0) at the very next clock.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hCount <= '0;
            r_vCount <= '0;
        end else if (i_pixEn) begin
            if (w_hLast) begin
                r_hCount <= '0;
                if (w_vLast) begin
                    r_vCount <= '0;
                end else begin
                    r_vCount <= r_vCount + 11'd1;
                end
            end else begin
                r_hCount <= r_hCount + 11'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 0: raw sync and active decoded straight from the counters. These
    // describe the pixel currently presented on o_X/o_Y.
    // ------------------------------------------------------------------------
    assign w_active = (r_hCount < C_H_VIS) && (r_vCount < C_V_VIS);
    assign w_hs0    = ((r_hCount >= C_HS_START) && (r_hCount < C_HS_END))
                      ? C_SYNC_ON : C_SYNC_OFF;
    assign w_vs0    = ((r_vCount >= C_VS_START) && (r_vCount < C_VS_END))
                      ? C_SYNC_ON : C_SYNC_OFF;
    assign w_stage0 = {w_hs0, w_vs0, w_active};

    // ------------------------------------------------------------------------
    // Delay line matching the external render pipeline. It only shifts on a
    // pixel tick, so a pixel's sync/active flags stay aligned with the colour
    // that the widgets return for it. With no render pipeline the stage-0
    // flags feed the output register directly.
    // ------------------------------------------------------------------------
    generate
        if (PIPE == 0) begin : g_noPipe
            assign w_stageN = w_stage0;
        end else begin : g_pipe
            logic [2:0] r_pipe [PIPE];

            // Shift register of {hs, vs, act}; cleared to blank on reset so
            // no partial sync pulse survives a reset.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < PIPE; i++) begin
                        r_pipe[i] <= C_STAGE_IDLE;
                    end
                end else if (i_pixEn) begin
                    r_pipe[0] <= w_stage0;
                    for (int i = 1; i < PIPE; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign w_stageN = r_pipe[PIPE-1];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Output register for the DAC pins. Sync comes from the end of the delay
    // line; colour is taken from the widgets only while the delayed active
    // flag is set, so nothing leaks into the blanking interval.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hsync <= C_SYNC_OFF;
            r_vsync <= C_SYNC_OFF;
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else if (i_pixEn) begin
            r_hsync <= w_stageN[2];
            r_vsync <= w_stageN[1];
            if (w_stageN[0]) begin
                r_red   <= i_redIn;
                r_green <= i_greenIn;
                r_blue  <= i_blueIn;
            end else begin
                r_red   <= '0;
                r_green <= '0;
                r_blue  <= '0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Frame tick. It fires for exactly one clock after the pixel tick that
    // leaves the last visible line, i.e. the move to (0, V_VISIBLE). Because
    // it is recomputed on every clock (not only on pixel ticks) it drops
    // after one clock even when the pixel enable is slow.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frameTick <= 1'b0;
        end else begin
            r_frameTick <= i_pixEn && w_hLast && (r_vCount == C_V_VIS_LAST);
        end
    end

    // ------------------------------------------------------------------------
    // Port assignments
    // ------------------------------------------------------------------------
    assign o_X         = r_hCount;
    assign o_Y         = r_vCount;
    assign o_active    = w_active;
    assign o_frameTick = r_frameTick;
    assign o_hsync     = r_hsync;
    assign o_vsync     = r_vsync;
    assign o_red       = r_red;
    assign o_green     = r_green;
    assign o_blue      = r_blue;

endmodule

// File: tb/tb_vga_scan_gen.sv
// ============================================================================
// tb_vga_scan_gen
// ----------------------------------------------------------------------------
// Three scan generators share clock, reset, pixel enable and colour input:
//   A : full 800x600 timing, PIPE=0, positive sync
//   B : small 32x20 raster, PIPE=3, negative sync
//   C : small 32x20 raster, PIPE=0, positive sync
// A reference model counts pixel ticks since the last reset and derives the
// expected coordinates, sync, blank and colour of every DUT from that count
// with plain modular arithmetic. A short directed section pins the model
// with hand-computed values, then a long randomized section varies the pixel
// enable pattern, colour and reset.
// ============================================================================
module tb_vga_scan_gen;

    typedef struct {
        int hv;
        int hf;
        int hsw;
        int hb;
        int vv;
        int vf;
        int vsw;
        int vb;
        int pipe;
        bit pol;
    } geom_t;

    geom_t gA = '{800, 40, 128, 88, 600, 1, 4, 23, 0, 1'b1};
    geom_t gB = '{16, 4, 8, 4, 12, 1, 4, 3, 3, 1'b0};
    geom_t gC = '{16, 4, 8, 4, 12, 1, 4, 3, 0, 1'b1};

    // Shared stimulus
    logic        clk = 1'b0;
    logic        reset;
    logic        pixEn;
    logic [11:0] rgbIn;

    // DUT outputs
    logic [10:0] xA, yA, xB, yB, xC, yC;
    logic        actA, actB, actC, ftA, ftB, ftC;
    logic        hsA, hsB, hsC, vsA, vsB, vsC;
    logic [3:0]  rA, gnA, bA, rB, gnB, bB, rC, gnC, bC;

    // Reference model state
    int          t = 0;
    logic        lastTick = 1'b0;
    logic        modelValid = 1'b0;
    logic [11:0] rgbHist [0:65535];

    // Bookkeeping
    int nCompared = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    vga_scan_gen #(
        .H_VISIBLE(800), .H_FRONT(40), .H_SYNC(128), .H_BACK(88),
        .V_VISIBLE(600), .V_FRONT(1), .V_SYNC(4), .V_BACK(23),
        .SYNC_POL(1'b1), .PIPE(0)
    ) dutA (
        .clk(clk), .reset(reset), .i_pixEn(pixEn),
        .o_X(xA), .o_Y(yA), .o_active(actA), .o_frameTick(ftA),
        .i_redIn(rgbIn[11:8]), .i_greenIn(rgbIn[7:4]), .i_blueIn(rgbIn[3:0]),
        .o_hsync(hsA), .o_vsync(vsA),
        .o_red(rA), .o_green(gnA), .o_blue(bA)
    );

    vga_scan_gen #(
        .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_VISIBLE(12), .V_FRONT(1), .V_SYNC(4), .V_BACK(3),
        .SYNC_POL(1'b0), .PIPE(3)
    ) dutB (
        .clk(clk), .reset(reset), .i_pixEn(pixEn),
        .o_X(xB), .o_Y(yB), .o_active(actB), .o_frameTick(ftB),
        .i_redIn(rgbIn[11:8]), .i_greenIn(rgbIn[7:4]), .i_blueIn(rgbIn[3:0]),
        .o_hsync(hsB), .o_vsync(vsB),
        .o_red(rB), .o_green(gnB), .o_blue(bB)
    );

    vga_scan_gen #(
        .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_VISIBLE(12), .V_FRONT(1), .V_SYNC(4), .V_BACK(3),
        .SYNC_POL(1'b1), .PIPE(0)
    ) dutC (
        .clk(clk), .reset(reset), .i_pixEn(pixEn),
        .o_X(xC), .o_Y(yC), .o_active(actC), .o_frameTick(ftC),
        .i_redIn(rgbIn[11:8]), .i_greenIn(rgbIn[7:4]), .i_blueIn(rgbIn[3:0]),
        .o_hsync(hsC), .o_vsync(vsC),
        .o_red(rC), .o_green(gnC), .o_blue(bC)
    );

    // ------------------------------------------------------------------------
    // Model: coordinate of pixel tick j since reset, and what the raster
    // rules say about that coordinate.
    // ------------------------------------------------------------------------
    function automatic int hTot(geom_t g);
        return g.hv + g.hf + g.hsw + g.hb;
    endfunction

    function automatic int vTot(geom_t g);
        return g.vv + g.vf + g.vsw + g.vb;
    endfunction

    function automatic int xAt(geom_t g, int j);
        return j % hTot(g);
    endfunction

    function automatic int yAt(geom_t g, int j);
        return (j / hTot(g)) % vTot(g);
    endfunction

    function automatic logic actAt(geom_t g, int j);
        return (xAt(g, j) < g.hv) && (yAt(g, j) < g.vv);
    endfunction

    function automatic logic hsAt(geom_t g, int j);
        int x;
        x = xAt(g, j);
        return ((x >= g.hv + g.hf) && (x < g.hv + g.hf + g.hsw)) ? g.pol : !g.pol;
    endfunction

    function automatic logic vsAt(geom_t g, int j);
        int y;
        y = yAt(g, j);
        return ((y >= g.vv + g.vf) && (y < g.vv + g.vf + g.vsw)) ? g.pol : !g.pol;
    endfunction

    // One comparison: counted, and reported on mismatch.
    task automatic cmp(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s at t=%0d: got %0h, expected %0h",
                     name, t, actual, expected);
        end
    endtask

    // Check every output of one DUT against the model at tick count t.
    task automatic checkOutput(input string nm, input geom_t g,
                               input logic [10:0] x, input logic [10:0] y,
                               input logic act, input logic ft,
                               input logic hs, input logic vs,
                               input logic [11:0] rgb);
        int          j;
        logic        expHs;
        logic        expVs;
        logic        expFt;
        logic [11:0] expRgb;
        j = t - g.pipe - 1;
        if (j < 0) begin
            expHs  = !g.pol;
            expVs  = !g.pol;
            expRgb = 12'h000;
        end else begin
            expHs  = hsAt(g, j);
            expVs  = vsAt(g, j);
            expRgb = actAt(g, j) ? rgbHist[t-1] : 12'h000;
        end
        expFt = lastTick && (xAt(g, t) == 0) && (yAt(g, t) == g.vv);
        cmp({nm, ".X"},         32'(x),      32'(xAt(g, t)));
        cmp({nm, ".Y"},         32'(y),      32'(yAt(g, t)));
        cmp({nm, ".active"},    32'(act),    32'(actAt(g, t)));
        cmp({nm, ".frameTick"}, 32'(ft),     32'(expFt));
        cmp({nm, ".hsync"},     32'(hs),     32'(expHs));
        cmp({nm, ".vsync"},     32'(vs),     32'(expVs));
        cmp({nm, ".rgb"},       32'(rgb),    32'(expRgb));
    endtask

    // Model update on every clock edge: count pixel ticks since reset and
    // remember the colour offered on each tick.
    always @(posedge clk) begin
        if (reset) begin
            t          <= 0;
            lastTick   <= 1'b0;
            modelValid <= 1'b1;
        end else if (pixEn) begin
            if (modelValid && t < 65535) begin
                rgbHist[t] <= rgbIn;
                t          <= t + 1;
            end
            lastTick <= 1'b1;
        end else begin
            lastTick <= 1'b0;
        end
    end

    // Compare process: every DUT, every cycle, on the inactive clock edge.
    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("A", gA, xA, yA, actA, ftA, hsA, vsA, {rA, gnA, bA});
            checkOutput("B", gB, xB, yB, actB, ftB, hsB, vsB, {rB, gnB, bB});
            checkOutput("C", gC, xC, yC, actC, ftC, hsC, vsC, {rC, gnC, bC});
        end
    end

    // Drive one clock's worth of inputs, then move just past the edge.
    task automatic applyStimulus(input logic rst, input logic en,
                                 input logic [11:0] rgb);
        reset = rst;
        pixEn = en;
        rgbIn = rgb;
        @(posedge clk);
        #1;
    endtask

    task automatic runTicks(input int n, input logic [11:0] rgb);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b1, rgb);
        end
    endtask

    initial begin
        int   mode;
        logic en;
        logic rst;
        logic syncReset;
        logic didSyncReset;

        reset = 1'b1;
        pixEn = 1'b0;
        rgbIn = 12'h000;
        didSyncReset = 1'b0;

        // --------------------------------------------------------------
        // Directed: reset values and hand-computed timing points
        // --------------------------------------------------------------
        applyStimulus(1'b1, 1'b1, 12'hF00);
        applyStimulus(1'b1, 1'b0, 12'hF00);
        cmp("pin A.X reset",      32'(xA),  32'd0);
        cmp("pin A.Y reset",      32'(yA),  32'd0);
        cmp("pin A.active reset", 32'(actA), 32'd1);
        cmp("pin A.hsync reset",  32'(hsA), 32'd0);
        cmp("pin A.vsync reset",  32'(vsA), 32'd0);
        cmp("pin A.rgb reset",    32'({rA, gnA, bA}), 32'h000);
        cmp("pin A.frameTick reset", 32'(ftA), 32'd0);
        cmp("pin B.hsync reset",  32'(hsB), 32'd1);
        cmp("pin B.vsync reset",  32'(vsB), 32'd1);

        runTicks(3, 12'hF00);
        cmp("pin B.rgb t3",   32'({rB, gnB, bB}), 32'h000);
        runTicks(1, 12'hF00);
        cmp("pin B.rgb t4",   32'({rB, gnB, bB}), 32'hF00);
        runTicks(19, 12'hF00);
        cmp("pin B.hsync t23", 32'(hsB), 32'd1);
        runTicks(1, 12'hF00);
        cmp("pin B.hsync t24", 32'(hsB), 32'd0);
        runTicks(776, 12'hF00);
        cmp("pin A.rgb t800", 32'({rA, gnA, bA}), 32'hF00);
        runTicks(1, 12'hF00);
        cmp("pin A.rgb t801", 32'({rA, gnA, bA}), 32'h000);
        runTicks(39, 12'hF00);
        cmp("pin A.X t840",     32'(xA),  32'd840);
        cmp("pin A.hsync t840", 32'(hsA), 32'd0);
        runTicks(1, 12'hF00);
        cmp("pin A.hsync t841", 32'(hsA), 32'd1);
        runTicks(215, 12'hF00);
        cmp("pin A.X t1056", 32'(xA), 32'd0);
        cmp("pin A.Y t1056", 32'(yA), 32'd1);

        applyStimulus(1'b1, 1'b1, 12'h0F0);
        runTicks(384, 12'h0F0);
        cmp("pin C.frameTick t384", 32'(ftC), 32'd1);
        cmp("pin C.X t384",         32'(xC),  32'd0);
        cmp("pin C.Y t384",         32'(yC),  32'd12);
        applyStimulus(1'b0, 1'b0, 12'h0F0);
        cmp("pin C.frameTick hold", 32'(ftC), 32'd0);
        cmp("pin C.Y hold",         32'(yC),  32'd12);

        // --------------------------------------------------------------
        // Randomized: enable pattern, colour and occasional reset
        // --------------------------------------------------------------
        mode = 0;
        for (int cyc = 0; cyc < 30000; cyc++) begin
            if (cyc % 500 == 0) begin
                mode = $urandom_range(0, 2);
            end
            case (mode)
                0:       en = 1'b1;
                1:       en = (cyc % 4 == 0);
                default: en = 1'($urandom_range(0, 1));
            endcase
            syncReset = !didSyncReset && (xAt(gC, t) == 22) && (yAt(gC, t) == 14);
            rst = syncReset || ($urandom_range(0, 3999) == 0);
            applyStimulus(rst, en, 12'($urandom));
            if (syncReset) begin
                didSyncReset = 1'b1;
                cmp("pin C.X syncReset",     32'(xC),  32'd0);
                cmp("pin C.Y syncReset",     32'(yC),  32'd0);
                cmp("pin C.hsync syncReset", 32'(hsC), 32'd0);
                cmp("pin C.vsync syncReset", 32'(vsC), 32'd0);
                cmp("pin C.rgb syncReset",   32'({rC, gnC, bC}), 32'h000);
                cmp("pin C.ft syncReset",    32'(ftC), 32'd0);
            end
        end

        if (!didSyncReset) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL syncReset: got never-reached, expected reset inside both syncs");
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
